// File: rtl/uart_alu_top.sv
// UART ALU: 8N1 byte receiver, packet FSM (echo/add/mul), TX byte FIFO and 8N1 transmitter.
// Bit period is 8*PRESCALE clocks; results are sent LSB first.
module uart_alu_top #(
  parameter int PRESCALE   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tx_o
);

  localparam logic [15:0] BIT_LAST  = 16'(8 * PRESCALE - 1);
  localparam logic [15:0] HALF_LAST = 16'(4 * PRESCALE - 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'h88;

  typedef enum logic [2:0] {HDR0, HDR1, LEN_LO, LEN_HI, PAYLOAD, RESULT} state_t;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_busy_q, rx_busy_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_ferr_q, rx_ferr_d;

  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [7:0]  fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic        fifo_full, fifo_empty, push, push_ok, pop;
  logic [7:0]  push_data;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] len_q, len_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  word_idx_q, word_idx_d;
  logic        have_op_q, have_op_d;
  logic [1:0]  res_idx_q, res_idx_d;
  logic        is_arith;
  logic [31:0] full_word;
  logic [15:0] len_full;

  logic        tx_busy_q, tx_busy_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_idx_q, tx_idx_d;

  // Receiver: half a bit after the start edge lands mid start bit, then whole bits.
  always_comb begin
    rx_busy_d  = rx_busy_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    if (!rx_busy_q) begin
      if (rx_prev_q && !rx_sync_q) begin
        rx_busy_d = 1'b1;
        rx_cnt_d  = HALF_LAST;
        rx_idx_d  = 4'd0;
      end
    end else if (rx_cnt_q != 16'd0) begin
      rx_cnt_d = rx_cnt_q - 16'd1;
    end else begin
      rx_cnt_d = BIT_LAST;
      rx_idx_d = rx_idx_q + 4'd1;
      if (rx_idx_q == 4'd0) begin
        if (rx_sync_q) rx_busy_d = 1'b0;
      end else if (rx_idx_q == 4'd9) begin
        rx_busy_d  = 1'b0;
        rx_valid_d = rx_sync_q;
        rx_ferr_d  = !rx_sync_q;
      end else begin
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
      end
    end
  end

  assign fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign is_arith   = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
  assign full_word  = {rx_shift_q, word_q};
  assign len_full   = {rx_shift_q, len_q[7:0]};

  // Packet FSM; a frame error anywhere abandons the current packet.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    acc_d      = acc_q;
    word_d     = word_q;
    word_idx_d = word_idx_q;
    have_op_d  = have_op_q;
    res_idx_d  = res_idx_q;
    push       = 1'b0;
    push_data  = 8'h00;
    if (rx_ferr_q) begin
      state_d    = HDR0;
      byte_cnt_d = 16'd0;
    end else begin
      case (state_q)
        HDR0: if (rx_valid_q) begin
          opcode_d   = rx_shift_q;
          byte_cnt_d = 16'd1;
          state_d    = HDR1;
        end
        HDR1: if (rx_valid_q) begin
          byte_cnt_d = 16'd2;
          state_d    = LEN_LO;
        end
        LEN_LO: if (rx_valid_q) begin
          len_d[7:0] = rx_shift_q;
          byte_cnt_d = 16'd3;
          state_d    = LEN_HI;
        end
        LEN_HI: if (rx_valid_q) begin
          len_d       = len_full;
          byte_cnt_d  = 16'd4;
          acc_d       = 32'd0;
          have_op_d   = 1'b0;
          word_idx_d  = 2'd0;
          res_idx_d   = 2'd0;
          if (len_full > 16'd4) state_d = PAYLOAD;
          else if (is_arith)    state_d = RESULT;
          else                  state_d = HDR0;
        end
        PAYLOAD: if (rx_valid_q) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (opcode_q == OP_ECHO && !fifo_full) begin
            push      = 1'b1;
            push_data = rx_shift_q;
          end
          if (is_arith) begin
            word_idx_d = word_idx_q + 2'd1;
            word_d     = {rx_shift_q, word_q[23:8]};
            if (word_idx_q == 2'd3) begin
              have_op_d = 1'b1;
              if (!have_op_q)              acc_d = full_word;
              else if (opcode_q == OP_ADD) acc_d = acc_q + full_word;
              else                         acc_d = acc_q * full_word;
            end
          end
          if (byte_cnt_q + 16'd1 == len_q) state_d = is_arith ? RESULT : HDR0;
        end
        RESULT: if (!fifo_full) begin
          push      = 1'b1;
          push_data = acc_q[8*res_idx_q +: 8];
          res_idx_d = res_idx_q + 2'd1;
          if (res_idx_q == 2'd3) state_d = HDR0;
        end
        default: state_d = HDR0;
      endcase
    end
  end

  assign push_ok = push && !fifo_full;

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    fifo_cnt_d = fifo_cnt_q + CW'(push_ok) - CW'(pop);
  end

  // Transmitter: tx_o is the LSB of the frame shifter, so the idle all-ones value drives the line high.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    pop        = 1'b0;
    if (tx_busy_q && tx_cnt_q != 16'd0) begin
      tx_cnt_d = tx_cnt_q - 16'd1;
    end else if (tx_busy_q && tx_idx_q != 4'd9) begin
      tx_cnt_d   = BIT_LAST;
      tx_idx_d   = tx_idx_q + 4'd1;
      tx_shift_d = {1'b1, tx_shift_q[9:1]};
    end else if (!fifo_empty) begin
      pop        = 1'b1;
      tx_busy_d  = 1'b1;
      tx_shift_d = {1'b1, fifo_mem_q[rd_ptr_q], 1'b0};
      tx_cnt_d   = BIT_LAST;
      tx_idx_d   = 4'd0;
    end else begin
      tx_busy_d  = 1'b0;
      tx_shift_d = '1;
    end
  end

  assign tx_o = tx_shift_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= 16'd0;
      rx_idx_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      fifo_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      state_q    <= HDR0;
      opcode_q   <= 8'h00;
      len_q      <= 16'd0;
      byte_cnt_q <= 16'd0;
      acc_q      <= 32'd0;
      word_q     <= 24'd0;
      word_idx_q <= 2'd0;
      have_op_q  <= 1'b0;
      res_idx_q  <= 2'd0;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_cnt_q   <= 16'd0;
      tx_idx_q   <= 4'd0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_busy_q  <= rx_busy_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      acc_q      <= acc_d;
      word_q     <= word_d;
      word_idx_q <= word_idx_d;
      have_op_q  <= have_op_d;
      res_idx_q  <= res_idx_d;
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_alu_top.sv
// Directed bench for uart_alu_top: a host-side UART drives rx_i and decodes tx_o into a byte queue,
// and each packet's returned bytes are compared against hand-computed values.
module tb_uart_alu_top;

  logic clk = 1'b0;
  logic rst;
  logic rx_i;
  logic tx_o;

  int vectors     = 0;
  int miscompares = 0;
  int frame_errs  = 0;
  int fe_base     = 0;
  int low_cnt     = 0;
  logic [7:0] rx_q[$];
  logic [7:0] mon_byte;
  logic [7:0] pkt[$];
  logic [7:0] exp_bytes[$];

  always #5 clk = ~clk;

  uart_alu_top #(.PRESCALE(1), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx_i (rx_i),
    .tx_o (tx_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = frame[i];
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] bytes[$]);
    @(negedge clk);
    foreach (bytes[i]) sendByte(bytes[i], 1'b1);
  endtask

  task automatic expectBytes(input string tag, input logic [7:0] want[$]);
    int waited;
    waited = 0;
    while (rx_q.size() < want.size() && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (rx_q.size() < want.size())
      checkOutput({tag, "_timeout"}, rx_q.size(), want.size());
    else
      foreach (want[i]) checkOutput($sformatf("%s_b%0d", tag, i), rx_q.pop_front(), want[i]);
  endtask

  task automatic expectQuiet(input string tag, input int cycles);
    repeat (cycles) @(negedge clk);
    checkOutput(tag, rx_q.size(), 0);
  endtask

  // Host receiver: sample each tx_o bit near its middle, stop bit must be high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_o === 1'b0) begin
        repeat (4) @(negedge clk);
        if (tx_o !== 1'b0) continue;
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk);
          mon_byte[i] = tx_o;
        end
        repeat (8) @(negedge clk);
        if (tx_o !== 1'b1) frame_errs++;
        else rx_q.push_back(mon_byte);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_high", tx_o, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx_o !== 1'b1) low_cnt++;
    end
    checkOutput("idle_after_reset_low_cycles", low_cnt, 0);
    checkOutput("idle_after_reset_bytes", rx_q.size(), 0);

    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    applyStimulus(pkt);
    exp_bytes = '{8'h41, 8'h42, 8'h43};
    expectBytes("echo", exp_bytes);

    pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    applyStimulus(pkt);
    exp_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    expectBytes("add_wrap", exp_bytes);

    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    applyStimulus(pkt);
    exp_bytes = '{8'h0F, 8'h00, 8'h00, 8'h00};
    expectBytes("mul_3x5", exp_bytes);

    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    applyStimulus(pkt);
    exp_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    expectBytes("mul_2p32", exp_bytes);

    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
    applyStimulus(pkt);
    exp_bytes = '{8'h99};
    expectBytes("unknown_op", exp_bytes);
    expectQuiet("unknown_op_extra", 200);

    pkt = '{8'hEC, 8'h00, 8'h02, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
    applyStimulus(pkt);
    exp_bytes = '{8'h77};
    expectBytes("short_len", exp_bytes);

    pkt = '{8'hEC, 8'h00};
    applyStimulus(pkt);
    sendByte(8'h05, 1'b0);
    rx_i = 1'b1;
    repeat (16) @(negedge clk);
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h12};
    applyStimulus(pkt);
    exp_bytes = '{8'h12};
    expectBytes("frame_err", exp_bytes);

    pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
            8'hA0, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    applyStimulus(pkt);
    exp_bytes = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00};
    expectBytes("b2b_add", exp_bytes);
    checkOutput("tx_frame_errors", frame_errs, 0);

    // Echo a zero byte, then hit reset while its data bits hold the line low.
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h00};
    applyStimulus(pkt);
    repeat (20) @(negedge clk);
    checkOutput("pre_reset_tx_low", tx_o, 0);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset_tx_high", tx_o, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    rx_q.delete();
    fe_base = frame_errs;

    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    applyStimulus(pkt);
    exp_bytes = '{8'h5A};
    expectBytes("post_reset_echo", exp_bytes);
    checkOutput("post_reset_frame_errors", frame_errs - fe_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
